io_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 16-bit Avalon IO bus.
- Master 0 is the CPU IO port (the io_read/io_write sequencer output). Master 1 is an auxiliary requester (DMA engine or debug bridge).
- Grants the shared IO slave bus by round-robin and routes readdatavalid back to the owning master.
- Keeps at most one transaction in flight, so IO device side effects stay strictly ordered.

---
 rtl/io_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter for the 16-bit Avalon IO bus, one transaction in flight.
// Optional read watchdog enabled by defining IO_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module io_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] m0_address,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [15:0] m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [15:0] s_address,
   output logic [3:0]  s_byteenable,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid,
   input  logic        s_waitrequest
);
   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, WAIT_RD} state_t;
   state_t      r_state, w_next;
   logic        r_owner, w_next_owner;
   logic        w_req0, w_req1, w_rdv, w_timeout;
   logic [15:0] w_m_addr;
   logic [3:0]  w_m_be;
   logic [31:0] w_m_wdata, w_rdata;
   logic        w_m_rd, w_m_wr;

   assign w_req0    = m0_read | m0_write;
   assign w_req1    = m1_read | m1_write;
   assign w_m_addr  = r_owner ? m1_address : m0_address;
   assign w_m_be    = r_owner ? m1_byteenable : m0_byteenable;
   assign w_m_wdata = r_owner ? m1_writedata : m0_writedata;
   assign w_m_rd    = r_owner ? m1_read : m0_read;
   assign w_m_wr    = r_owner ? m1_write : m0_write;

`ifdef IO_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= (r_state == WAIT_RD) ? r_cnt + 16'd1 : 16'd0;
   end
   assign w_timeout = (r_state == WAIT_RD) && (r_cnt == 16'(TIMEOUT_CYCLES));
   // Real data beats the watchdog when both land in the same cycle.
   assign w_rdata   = (w_timeout && !s_readdatavalid) ? 32'hFFFF_FFFF : s_readdata;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^16'(TIMEOUT_CYCLES);
   assign w_timeout = 1'b0;
   assign w_rdata   = s_readdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_owner <= 1'b1;
      end else begin
         r_state <= w_next;
         r_owner <= w_next_owner;
      end
   end

   always_comb begin
      w_next         = r_state;
      w_next_owner   = r_owner;
      s_address      = '0;
      s_byteenable   = '0;
      s_writedata    = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      w_rdv          = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 | w_req1) begin
               w_next_owner = (w_req0 & w_req1) ? ~r_owner : w_req1;
               w_next       = w_next_owner ? GRANT1 : GRANT0;
            end
         end
         GRANT0, GRANT1: begin
            s_address      = w_m_addr;
            s_byteenable   = w_m_be;
            s_writedata    = w_m_wdata;
            s_write        = w_m_wr;
            s_read         = w_m_rd & ~w_m_wr;
            m0_waitrequest = r_owner | s_waitrequest;
            m1_waitrequest = ~r_owner | s_waitrequest;
            // A master that withdrew its request simply releases the bus.
            if (!w_m_rd && !w_m_wr) w_next = IDLE;
            else if (!s_waitrequest) begin
               if (w_m_wr) w_next = IDLE;
               else if (s_readdatavalid) begin
                  w_rdv  = 1'b1;
                  w_next = IDLE;
               end else w_next = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (s_readdatavalid || w_timeout) begin
               w_rdv  = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign m0_readdatavalid = w_rdv & ~r_owner;
   assign m1_readdatavalid = w_rdv & r_owner;
   assign m0_readdata      = w_rdata;
   assign m1_readdata      = w_rdata;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: table-driven cycle vectors with a scoreboard queue for io_bus_arbiter.
module tb_io_bus_arbiter;
   localparam logic [15:0] A0 = 16'h0060, A1 = 16'h0080;
   localparam logic [3:0]  B0 = 4'hF, B1 = 4'h3;
   localparam logic [31:0] D0 = 32'h0000_00AB, D1 = 32'h0000_00CD;
   localparam logic [5:0]  IDL = 6'b001100;

   typedef struct {
      logic [5:0]  in;
      logic [31:0] rd;
      logic [1:0]  own;
      logic [5:0]  out;
      logic [31:0] erd;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic m0_read, m0_write, m1_read, m1_write;
   logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata, s_writedata, s_readdata;
   logic [15:0] s_address;
   logic [3:0]  s_byteenable;
   logic s_read, s_write, s_readdatavalid, s_waitrequest;
   vec_t vecs[$];
   vec_t exp_q[$];
   int n_chk = 0, n_err = 0, idx = 0;

   always #5 clk = ~clk;

   io_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(A0), .m0_byteenable(B0), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(D0), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(A1), .m1_byteenable(B1), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(D1), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .s_waitrequest(s_waitrequest)
   );

   // in = {m0_read,m0_write,m1_read,m1_write,s_waitrequest,s_readdatavalid}
   // out = {s_read,s_write,m0_waitrequest,m1_waitrequest,m0_rdv,m1_rdv}; own: 0 none, 1 m0, 2 m1
   function automatic void add(input logic [5:0] in, input logic [31:0] rd,
                               input logic [1:0] own, input logic [5:0] out);
      vec_t v;
      v.in = in; v.rd = rd; v.own = own; v.out = out; v.erd = rd;
      vecs.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = v.in;
      s_readdata = v.rd;
   endtask

   task automatic check(input vec_t v);
      logic [5:0]  st;
      logic [51:0] cmd, ecmd;
      st   = {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid};
      cmd  = {s_address, s_byteenable, s_writedata};
      ecmd = (v.own == 2'd1) ? {A0, B0, D0} : (v.own == 2'd2) ? {A1, B1, D1} : 52'd0;
      n_chk++;
      if (st !== v.out) begin
         n_err++;
         $display("FAIL strobes vec %0d: got %b want %b", idx, st, v.out);
      end
      n_chk++;
      if (cmd !== ecmd) begin
         n_err++;
         $display("FAIL slave_cmd vec %0d: got %h want %h", idx, cmd, ecmd);
      end
      if (v.out[1] | v.out[0]) begin
         n_chk++;
         if ({m0_readdata, m1_readdata} !== {v.erd, v.erd}) begin
            n_err++;
            $display("FAIL readdata vec %0d: got %h/%h want %h", idx, m0_readdata, m1_readdata, v.erd);
         end
      end
   endtask

   task automatic run_vecs();
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         check(exp_q.pop_front());
         idx++;
      end
      vecs.delete();
   endtask

   task automatic do_reset();
      vec_t rv;
      rv.in = '0; rv.rd = '0; rv.own = 2'd0; rv.out = IDL; rv.erd = '0;
      drive(rv);
      rst_n = 1'b0;
      #1;
      check(rv);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      // Simultaneous reads after reset: m0 first, 3-cycle read latency, then m1.
      add(6'b101000, 0, 0, IDL);
      add(6'b101000, 0, 1, 6'b100100);
      add(6'b001000, 0, 0, IDL);
      add(6'b001000, 0, 0, IDL);
      add(6'b001001, 32'h1111_0000, 0, 6'b001110);
      add(6'b001000, 0, 0, IDL);
      add(6'b001000, 0, 2, 6'b101000);
      add(6'b000000, 0, 0, IDL);
      add(6'b000000, 0, 0, IDL);
      add(6'b000001, 32'h2222_0000, 0, 6'b001101);
      // Single write from m0.
      add(6'b010000, 0, 0, IDL);
      add(6'b010000, 0, 1, 6'b010100);
      add(6'b000000, 0, 0, IDL);
      // Back-to-back write contention; last grant was m0 so m1 leads.
      for (int t = 0; t < 8; t++) begin
         add(6'b010100, 0, 0, IDL);
         add(6'b010100, 0, (t % 2 == 1) ? 2'd1 : 2'd2, (t % 2 == 1) ? 6'b010100 : 6'b011000);
      end
      add(6'b000000, 0, 0, IDL);
      // Zero-latency read for m1.
      add(6'b001000, 0, 0, IDL);
      add(6'b001001, 32'h1234_5678, 2, 6'b101001);
      add(6'b000000, 0, 0, IDL);
      // Slave stall during GRANT0 with m1 also pending.
      add(6'b101000, 0, 0, IDL);
      for (int t = 0; t < 5; t++) add(6'b101010, 0, 1, 6'b101100);
      add(6'b101001, 32'hCAFE_0000, 1, 6'b100110);
      add(6'b001000, 0, 0, IDL);
      add(6'b001001, 32'h5555_0000, 2, 6'b101001);
      add(6'b000001, 32'h9999_0000, 0, IDL);
      // Read and write together is a write.
      add(6'b110000, 0, 0, IDL);
      add(6'b110000, 0, 1, 6'b010100);
      add(6'b000000, 0, 0, IDL);
      // Leave a read outstanding, then reset under it.
      add(6'b100000, 0, 0, IDL);
      add(6'b100000, 0, 1, 6'b100100);
      add(6'b000000, 0, 0, IDL);
      run_vecs();
      do_reset();
      add(6'b000001, 32'hDEAD_0000, 0, IDL);
      add(6'b101000, 0, 0, IDL);
      add(6'b101000, 0, 1, 6'b100100);
      add(6'b001001, 32'h0000_0001, 0, 6'b001110);
      add(6'b000000, 0, 0, IDL);
      run_vecs();
`ifdef IO_ARB_TIMEOUT_EN
      add(6'b100000, 0, 0, IDL);
      add(6'b100000, 0, 1, 6'b100100);
      for (int t = 0; t < 4; t++) add(6'b000000, 0, 0, IDL);
      add(6'b000000, 0, 0, 6'b001110);
      vecs[vecs.size() - 1].erd = 32'hFFFF_FFFF;
      add(6'b000000, 0, 0, IDL);
      add(6'b000001, 32'h7777_0000, 0, IDL);
      run_vecs();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
